prog_loader: RTL

- Byte-stream program loader: the writer side of the processor's 256x16 instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word into instruction memory through a single write port.
- Holds the processor in reset until a complete, checksum-verified image is loaded.

---
 rtl/prog_loader_if.sv | 36 +++
 rtl/prog_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input handshake plus instruction-memory write
// port and processor control outputs of the program loader.
//
// Signals:
//   in_valid / in_data / in_ready  byte stream, transfer when valid & ready
//   mem_we / mem_addr / mem_wdata  instruction memory write port
//   cpu_rst                        active-high processor reset
//   busy / done / err              loader status
//
// Modports:
//   master  stream source and memory/status observer
//   slave   the loader itself
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: writer side of the processor's instruction memory.
// Accepts a framed byte stream SYNC, COUNT, ADDR, N x (HI, LO) [, CSUM],
// assembles 16-bit words high byte first and writes each one through a
// single write port. The processor is held in reset until a complete image
// has been loaded.
//
// Parameters:
//   ADDR_W     instruction memory address width (pointer wraps mod 2^ADDR_W)
//   SYNC_BYTE  frame start marker
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   prog_loader_if.slave (stream input, memory write port, status)
//
// Build option:
//   PROG_LOADER_CSUM_EN  when defined, a trailing CSUM byte (XOR of every
//   byte after SYNC) is expected and checked, and err is operative. When
//   undefined, the frame ends after the last LO byte and err is tied to 0.
module prog_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_ADDR,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [8:0]        count;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        hi;
  logic              cpu_rst_q;
  logic              fire;
  logic              last_word;
  logic              is_sync;

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]        csum;
  logic              err_q;
  logic              csum_ok;

  assign csum_ok = (bus.in_data == csum);
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Ready is gated by rst so the loader never claims a byte while it is
  // being reset; DONE is the only other cycle in which bytes are refused.
  assign bus.in_ready = rst && (state != S_DONE);
  assign fire         = bus.in_valid && bus.in_ready;
  assign last_word    = (count == 9'd1);
  assign is_sync      = (bus.in_data == SYNC_BYTE);
  assign bus.busy     = (state == S_COUNT) || (state == S_ADDR) ||
                        (state == S_HI)    || (state == S_LO)   ||
                        (state == S_CSUM);
  assign bus.done     = (state == S_DONE);
  assign bus.cpu_rst  = cpu_rst_q;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fire && is_sync) state_next = S_COUNT;
      S_COUNT: if (fire) state_next = S_ADDR;
      S_ADDR:  if (fire) state_next = S_HI;
      S_HI:    if (fire) state_next = S_LO;
`ifdef PROG_LOADER_CSUM_EN
      S_LO:    if (fire) state_next = last_word ? S_CSUM : S_HI;
      S_CSUM:  if (fire) state_next = csum_ok ? S_DONE : S_IDLE;
`else
      S_LO:    if (fire) state_next = last_word ? S_DONE : S_HI;
      S_CSUM:  state_next = S_IDLE;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      count         <= 9'd0;
      ptr           <= '0;
      hi            <= 8'd0;
      cpu_rst_q     <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 16'd0;
`ifdef PROG_LOADER_CSUM_EN
      csum          <= 8'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      bus.mem_we <= 1'b0;
      if (fire) begin
        case (state)
          S_IDLE: begin
            if (is_sync) begin
              cpu_rst_q <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
              csum      <= 8'd0;
              err_q     <= 1'b0;
`endif
            end
          end
          // A COUNT byte of zero stands for a full 256-word image.
          S_COUNT: count <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
          S_ADDR:  ptr   <= ADDR_W'(bus.in_data);
          S_HI:    hi    <= bus.in_data;
          S_LO: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= {hi, bus.in_data};
            ptr           <= ptr + 1'b1;
            count         <= count - 9'd1;
          end
`ifdef PROG_LOADER_CSUM_EN
          S_CSUM:  if (!csum_ok) err_q <= 1'b1;
`endif
          default: ;
        endcase
`ifdef PROG_LOADER_CSUM_EN
        // Running XOR covers COUNT, ADDR and every data byte.
        if ((state == S_COUNT) || (state == S_ADDR) ||
            (state == S_HI) || (state == S_LO))
          csum <= csum ^ bus.in_data;
`endif
      end
      // The processor is released only as the loader enters DONE.
      if (state_next == S_DONE) cpu_rst_q <= 1'b0;
    end
  end

endmodule
